decode_stage: RTL

Pipeline stage directly downstream of the fetch stage in the Y86-64 pipelined core. It holds the D pipeline register, which latches the fetch outputs. It also holds the 15-entry architectural register file, written from the W stage. Each cycle it produces the decoded operands (valA/valB), register IDs (srcA/srcB/dstE/dstM) and status for the execute stage, with full data forwarding from E/M/W.

---
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, 15-entry register file and
// E/M/W operand forwarding feeding the execute stage.
module decode_stage #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [3:0]        f_rA,
  input  logic [3:0]        f_rB,
  input  logic [DATA_W-1:0] f_valC,
  input  logic [DATA_W-1:0] f_valP,
  input  logic              f_instr_valid,
  input  logic              f_imem_error,
  input  logic              f_hlt,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  output logic [2:0]        d_stat,
  output logic [3:0]        d_icode,
  output logic [3:0]        d_ifun,
  output logic [DATA_W-1:0] d_valC,
  output logic [DATA_W-1:0] d_valA,
  output logic [DATA_W-1:0] d_valB,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        d_dstE,
  output logic [3:0]        d_dstM
);

  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [3:0] RRSP   = 4'h4;
  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_RRMV = 4'h2;
  localparam logic [3:0] I_IRMV = 4'h3;
  localparam logic [3:0] I_RMMV = 4'h4;
  localparam logic [3:0] I_MRMV = 4'h5;
  localparam logic [3:0] I_OPQ  = 4'h6;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] I_PUSH = 4'hA;
  localparam logic [3:0] I_POP  = 4'hB;
  localparam logic [2:0] S_AOK  = 3'd1;
  localparam logic [2:0] S_HLT  = 3'd2;
  localparam logic [2:0] S_ADR  = 3'd3;
  localparam logic [2:0] S_INS  = 3'd4;

  logic [3:0]        r_icode, r_ifun, r_rA, r_rB;
  logic [DATA_W-1:0] r_valC, r_valP;
  logic [2:0]        r_stat;
  logic [DATA_W-1:0] r_regs [NREG];

  logic [2:0] w_stat_ld;
  logic       w_no_regs;
  logic [3:0] w_srcA, w_srcB, w_dstE, w_dstM;

  always_comb begin
    if (f_imem_error)        w_stat_ld = S_ADR;
    else if (!f_instr_valid) w_stat_ld = S_INS;
    else if (f_hlt)          w_stat_ld = S_HLT;
    else                     w_stat_ld = S_AOK;
  end

  // Fetch leaves rA/rB undriven for these icodes; squash them to "none".
  assign w_no_regs = (f_icode == I_HALT) || (f_icode == I_NOP) || (f_icode == I_JXX) ||
                     (f_icode == I_CALL) || (f_icode == I_RET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icode <= I_NOP;
      r_ifun  <= 4'h0;
      r_rA    <= RNONE;
      r_rB    <= RNONE;
      r_valC  <= '0;
      r_valP  <= '0;
      r_stat  <= S_AOK;
    end else if (!D_stall) begin
      if (D_bubble) begin
        r_icode <= I_NOP;
        r_ifun  <= 4'h0;
        r_rA    <= RNONE;
        r_rB    <= RNONE;
        r_valC  <= '0;
        r_valP  <= '0;
        r_stat  <= S_AOK;
      end else begin
        r_icode <= f_icode;
        r_ifun  <= f_ifun;
        r_rA    <= w_no_regs ? RNONE : f_rA;
        r_rB    <= w_no_regs ? RNONE : f_rB;
        r_valC  <= f_valC;
        r_valP  <= f_valP;
        r_stat  <= w_stat_ld;
      end
    end
  end

  // Register file; the M port is applied last so it wins a same-register clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (W_dstM == 4'(k))      r_regs[k] <= W_valM;
        else if (W_dstE == 4'(k)) r_regs[k] <= W_valE;
      end
    end
  end

  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (r_icode)
      I_RRMV, I_RMMV, I_OPQ, I_PUSH: w_srcA = r_rA;
      I_RET, I_POP:                  w_srcA = RRSP;
      default:                       w_srcA = RNONE;
    endcase
    case (r_icode)
      I_RMMV, I_MRMV, I_OPQ:         w_srcB = r_rB;
      I_CALL, I_RET, I_PUSH, I_POP:  w_srcB = RRSP;
      default:                       w_srcB = RNONE;
    endcase
    case (r_icode)
      I_RRMV, I_IRMV, I_OPQ:         w_dstE = r_rB;
      I_CALL, I_RET, I_PUSH, I_POP:  w_dstE = RRSP;
      default:                       w_dstE = RNONE;
    endcase
    case (r_icode)
      I_MRMV, I_POP:                 w_dstM = r_rA;
      default:                       w_dstM = RNONE;
    endcase
  end

  // One forwarding read port per operand (0 = A, 1 = B).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [3:0]        w_sel;
      logic [DATA_W-1:0] w_rf;
      logic [DATA_W-1:0] w_val;

      assign w_sel = (gi == 0) ? w_srcA : w_srcB;

      always_comb begin
        w_rf = '0;
        for (int k = 0; k < NREG; k++) begin
          if (w_sel == 4'(k)) w_rf = r_regs[k];
        end
      end

      always_comb begin
        if (w_sel == RNONE)       w_val = '0;
        else if (w_sel == e_dstE) w_val = e_valE;
        else if (w_sel == M_dstM) w_val = m_valM;
        else if (w_sel == M_dstE) w_val = M_valE;
        else if (w_sel == W_dstM) w_val = W_valM;
        else if (w_sel == W_dstE) w_val = W_valE;
        else                      w_val = w_rf;
      end
    end
  endgenerate

  assign d_valA  = ((r_icode == I_JXX) || (r_icode == I_CALL)) ? r_valP : g_port[0].w_val;
  assign d_valB  = g_port[1].w_val;
  assign d_stat  = r_stat;
  assign d_icode = r_icode;
  assign d_ifun  = r_ifun;
  assign d_valC  = r_valC;
  assign d_srcA  = w_srcA;
  assign d_srcB  = w_srcB;
  assign d_dstE  = w_dstE;
  assign d_dstM  = w_dstM;

endmodule
